// File: rtl/botao_pedestre.sv
// botao_pedestre: pedestrian push-button conditioner feeding semaforo's bt input.
// Synchronizes and debounces a raw button, latches one crossing request until
// semaforo A is seen red, then holds off new requests for a cooldown period.
//
// Parameters:
//   DEBOUNCE  stable synchronized cycles before a new level is accepted (1..255)
//   COOLDOWN  cycles after the red phase during which presses are discarded (1..255)
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   btn_raw    raw button, asynchronous, may bounce
//   A          semaforo A lights, one-hot {vermelho, amarelo, verde}
//   bt         request level to semaforo, high while a request is pending
//   busy       high while serving or cooling down; presses are ignored
//   req_count  saturating count of accepted presses
module botao_pedestre #(
    parameter logic [7:0] DEBOUNCE = 8'd4,
    parameter logic [7:0] COOLDOWN = 8'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic [2:0] A,
    output logic       bt,
    output logic       busy,
    output logic [7:0] req_count
);

    typedef enum logic [1:0] {StIdle, StReq, StServed, StCool} state_t;

    state_t     state;
    logic       s1, s2;
    logic       deb, deb_d;
    logic [7:0] dcnt;
    logic [7:0] ccnt;
    logic       press;
    logic       red;

    // Two-flop synchronizer; only s2 is used downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // Debouncer: a new level must differ from deb for DEBOUNCE consecutive
    // samples; any return to deb restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb   <= 1'b0;
            deb_d <= 1'b0;
            dcnt  <= 8'd0;
        end else begin
            deb_d <= deb;
            if (s2 == deb) begin
                dcnt <= 8'd0;
            end else if (dcnt == DEBOUNCE - 8'd1) begin
                deb  <= s2;
                dcnt <= 8'd0;
            end else begin
                dcnt <= dcnt + 8'd1;
            end
        end
    end

    // One cycle per accepted rising level; falling levels give no event.
    assign press = deb & ~deb_d;
    // Non-one-hot codes are deliberately treated as not red.
    assign red   = (A == 3'b100);

    // Request FSM with registered outputs kept in step with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            ccnt      <= 8'd0;
            bt        <= 1'b0;
            busy      <= 1'b0;
            req_count <= 8'd0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (press) begin
                        state <= StReq;
                        bt    <= 1'b1;
                        if (req_count != 8'hFF) begin
                            req_count <= req_count + 8'd1;
                        end
                    end
                end
                StReq: begin
                    // Extra presses here merge into the pending request.
                    if (red) begin
                        state <= StServed;
                        bt    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                StServed: begin
                    if (!red) begin
                        state <= StCool;
                        ccnt  <= COOLDOWN - 8'd1;
                    end
                end
                StCool: begin
                    if (ccnt == 8'd0) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else begin
                        ccnt <= ccnt - 8'd1;
                    end
                end
                default: begin
                    state <= StIdle;
                    bt    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_botao_pedestre.sv
// Scoreboard bench for botao_pedestre (DEBOUNCE=4, COOLDOWN=8).
// Stimulus pushes {cycle, bt, busy, req_count} for every expected output change;
// the monitor pops and compares whenever the sampled outputs change.
module tb_botao_pedestre;

    logic       clk;
    logic       rst;
    logic       btn_raw;
    logic [2:0] A;
    logic       bt;
    logic       busy;
    logic [7:0] req_count;

    botao_pedestre #(
        .DEBOUNCE(8'd4),
        .COOLDOWN(8'd8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .A        (A),
        .bt       (bt),
        .busy     (busy),
        .req_count(req_count)
    );

    typedef struct packed {
        int unsigned cyc;
        logic        bt;
        logic        busy;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc;
    int          checks;
    int          errors;
    logic        mon_en;
    logic [9:0]  prev;
    int          mcnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input int unsigned c, input logic b, input logic bz,
                        input logic [7:0] n);
        exp_t e;
        e.cyc  = c;
        e.bt   = b;
        e.busy = bz;
        e.cnt  = n;
        q.push_back(e);
    endtask

    // From REQ: go red (SERVED next edge), release button, let deb settle low.
    task automatic go_red(input logic [7:0] n);
        A       = 3'b100;
        push(cyc + 1, 1'b0, 1'b1, n);
        btn_raw = 1'b0;
        tick(7);
    endtask

    // From SERVED: go green; COOL for 8 cycles, IDLE after edge +9.
    task automatic go_green(input logic [7:0] n);
        A = 3'b001;
        push(cyc + 9, 1'b0, 1'b0, n);
        tick(10);
    endtask

    // Full request from IDLE with a settled-low debouncer and A green.
    task automatic press_cycle(input logic [7:0] n);
        btn_raw = 1'b1;
        push(cyc + 7, 1'b1, 1'b0, n);
        tick(8);
        go_red(n);
        go_green(n);
    endtask

    // Monitor: compare on each change of the observed outputs.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && cyc > q[0].cyc) begin
                chk("missed_event_cycle", int'(cyc), int'(q[0].cyc));
                void'(q.pop_front());
            end
            if ({bt, busy, req_count} != prev) begin
                if (q.size() == 0) begin
                    chk("unexpected_change", int'({bt, busy, req_count}), int'(prev));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("evt_cycle", int'(cyc), int'(e.cyc));
                    chk("evt_bt", int'(bt), int'(e.bt));
                    chk("evt_busy", int'(busy), int'(e.busy));
                    chk("evt_req_count", int'(req_count), int'(e.cnt));
                end
                prev = {bt, busy, req_count};
            end
        end
    end

    initial begin
        int unsigned c;
        checks  = 0;
        errors  = 0;
        mon_en  = 1'b0;
        prev    = '0;
        rst     = 1'b0;
        btn_raw = 1'b0;
        A       = 3'b001;
        tick(2);
        chk("reset_bt", int'(bt), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_req_count", int'(req_count), 0);
        rst = 1'b1;
        tick(2);
        prev   = '0;
        mon_en = 1'b1;

        // Clean press, then ignored presses during SERVED and COOL.
        btn_raw = 1'b1;
        push(cyc + 7, 1'b1, 1'b0, 8'd1);
        tick(8);
        go_red(8'd1);
        tick(3);
        btn_raw = 1'b1;          // debounced press while SERVED
        tick(10);
        btn_raw = 1'b0;
        tick(10);
        btn_raw = 1'b1;          // rises in COOL, then held past cooldown
        go_green(8'd1);
        tick(14);
        chk("held_no_rerequest_bt", int'(bt), 0);
        chk("ignored_req_count", int'(req_count), 1);
        btn_raw = 1'b0;
        tick(10);

        // Bounce filter: 3 high samples, 1 low, then held high.
        c       = cyc;
        btn_raw = 1'b1;
        tick(3);
        btn_raw = 1'b0;
        tick(1);
        btn_raw = 1'b1;
        push(c + 11, 1'b1, 1'b0, 8'd2);
        tick(8);
        go_red(8'd2);
        go_green(8'd2);

        // Press while red: REQ for one cycle, then SERVED.
        A       = 3'b100;
        tick(2);
        btn_raw = 1'b1;
        push(cyc + 7, 1'b1, 1'b0, 8'd3);
        push(cyc + 8, 1'b0, 1'b1, 8'd3);
        tick(8);
        btn_raw = 1'b0;
        tick(7);
        go_green(8'd3);

        // Async reset while in REQ, button held through release.
        btn_raw = 1'b1;
        push(cyc + 7, 1'b1, 1'b0, 8'd4);
        tick(9);
        rst = 1'b0;
        push(cyc, 1'b0, 1'b0, 8'd0);
        #1;
        chk("async_rst_bt", int'(bt), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_req_count", int'(req_count), 0);
        tick(2);
        rst = 1'b1;
        push(cyc + 7, 1'b1, 1'b0, 8'd1);
        tick(8);
        go_red(8'd1);
        go_green(8'd1);

        // Saturation: count up to 255, then one more press still requests.
        mcnt = 1;
        while (mcnt < 255) begin
            mcnt++;
            press_cycle(8'(mcnt));
        end
        press_cycle(8'd255);

        tick(12);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/botao_pedestre.md
# botao_pedestre

Pedestrian push-button conditioner sitting directly upstream of `semaforo`, driving its `bt` input. It synchronizes and debounces a raw asynchronous button and latches one crossing request. It holds `bt` high until semaforo A is observed red, then enforces a cooldown before accepting a new request. It also keeps a saturating count of accepted requests for debug and waveform inspection.

## Interface
- `DEBOUNCE`, default 8'd4: consecutive synchronized cycles a new level must hold before it is accepted. Range 1..255.
- `COOLDOWN`, default 8'd8: cycles after the red phase ends during which presses are discarded. Range 1..255.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `btn_raw`  in  1  raw button; asynchronous to `clk` and may bounce.
- `A`  in  3  state of semaforo A, one-hot: [2] vermelho, [1] amarelo, [0] verde.
- `bt`  out  1  request to semaforo, level. High while a request is pending.
- `busy`  out  1  high in SERVED or COOL; presses are ignored while high.
- `req_count`  out  8  accepted presses; saturates at 255.

## Operation
- Synchronizer: two flops, `btn_raw` → `s1` → `s2`. Only `s2` is used downstream.
- Debouncer: holds level `deb` and 8-bit counter `dcnt`.
  - If `s2 == deb`: `dcnt <= 0`.
  - Else if `dcnt == DEBOUNCE-1`: `deb <= s2`, `dcnt <= 0`.
  - Else: `dcnt <= dcnt+1`.
  - Any return of `s2` to `deb` before acceptance restarts the count.
- Press event: `press = deb & ~deb_d`, where `deb_d` is `deb` registered. Exactly one cycle per accepted rising level. Falling levels produce no event.
- `red = (A == 3'b100)`. Any other value, including illegal non-one-hot codes, is not red.
- FSM (Moore):
  - IDLE: on `press` go to REQ and increment `req_count` (saturating).
  - REQ: on `red` go to SERVED. Further presses are merged: no count, no state change.
  - SERVED: stay while `red`. When `!red`, go to COOL and load `ccnt <= COOLDOWN-1`.
  - COOL: if `ccnt == 0` go to IDLE, else `ccnt <= ccnt-1`. Presses are discarded.
- Outputs: `bt = (state == REQ)`; `busy = (state == SERVED || state == COOL)`.
- A press in SERVED or COOL is dropped permanently; it is not queued. Holding the button through cooldown does not re-request; a new rising edge of `deb` is required.

## Timing
- Reset values: `s1`, `s2`, `deb`, `deb_d`, `dcnt`, `ccnt` = 0; state IDLE; `bt` = 0, `busy` = 0, `req_count` = 0.
- Reset acts immediately on assertion, without waiting for a clock.
- Press latency: `btn_raw` sampled high at edge k and held → `deb` rises at edge k+1+DEBOUNCE → `bt` high after edge k+2+DEBOUNCE. With DEBOUNCE=4, `bt` rises after edge k+6.
- A high pulse on `btn_raw` must be stable in `s2` for DEBOUNCE consecutive edges to be accepted. Shorter pulses are filtered.
- IDLE with `press` while `red` already holds: enter REQ (`bt` = 1 for one cycle), then SERVED on the next edge.
- REQ→SERVED: `bt` falls after the first edge that samples `red`.
- COOL lasts exactly COOLDOWN cycles. `busy` stays high from the SERVED entry through the last COOL cycle.
- Reset mid-operation (any state): everything returns to reset values. After release with the button held, `s2 = 1`, `deb = 0`, so a fresh debounce runs and produces a valid press.
- `req_count` at 255 plus an accepted press: stays 255 and the FSM still enters REQ.

## Test plan
- Clean press: DEBOUNCE=4, `A` = verde, `btn_raw` 0→1 sampled at edge 2 and held → `bt` = 1 after edge 8, `req_count` = 1, `busy` = 0.
- Bounce filter: `btn_raw` high for 3 edges, low for 1, then high and held → no `bt` until 4 consecutive stable `s2` samples, then `bt` = 1; exactly one count.
- Serve and cooldown: in REQ, drive `A` = 3'b100 at edge n → `bt` = 0 and `busy` = 1 after n. Drive `A` = 3'b001 at edge m → `busy` = 1 for 8 more cycles, then 0.
- Ignored presses: pulse (debounced) during SERVED and during COOL → `bt` stays 0, `req_count` unchanged, state returns to IDLE only.
- Press while red: IDLE, `A` = 3'b100, accepted press → `bt` high for exactly 1 cycle, then SERVED.
- Async reset in REQ: drive `rst` = 0 between edges → `bt`, `busy`, `req_count` = 0 immediately. Release with the button held → `bt` = 1 again after DEBOUNCE+2 edges, `req_count` = 1.
